// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered half-adder bank.
package half_adder_pkg;

    // Lane count used when the instantiating level does not override WIDTH.
    localparam int HA_DEFAULT_WIDTH = 1;

    // Result of one half-adder lane: sum bit and carry bit.
    typedef struct packed {
        logic s;
        logic c;
    } ha_res_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder built from gate primitives.
// The XOR is the classic four-NAND network; the carry reuses the first NAND.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    wire n_ab;
    wire n_a;
    wire n_b;

    nand u_nand_ab  (n_ab, a, b);
    nand u_nand_a   (n_a, a, n_ab);
    nand u_nand_b   (n_b, b, n_ab);
    nand u_nand_sum (s, n_a, n_b);
    not  u_not_cy   (c, n_ab);

endmodule : half_adder_cell

// File: rtl/half_adder_s.sv
// Registered bank of WIDTH independent half adders with a valid strobe.
// Optional feature macro: HA_CARRY_CNT_EN adds a saturating carry-event
// counter (carry_cnt) that accumulates popcount(a & b) on every valid edge.
module half_adder_s
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_DEFAULT_WIDTH
`ifdef HA_CARRY_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sout,
    output logic [WIDTH-1:0] cout,
    output logic             out_valid
`ifdef HA_CARRY_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] carry_w;

    ha_res_t [WIDTH-1:0] res_d;
    ha_res_t [WIDTH-1:0] res_q;
    logic                out_valid_d;
    logic                out_valid_q;

    // One structural cell per lane; lanes never exchange carries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .s (sum_w[i]),
            .c (carry_w[i])
        );
    end

    // Next result: capture the cell outputs on a valid cycle, otherwise hold.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        res_d       = res_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                res_d[i] = '{s: sum_w[i], c: carry_w[i]};
            end
        end
    end

    // Output stage registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
        if (rst) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Unpack the registered lane structs onto the flat output buses.
    always_comb begin
        sout = '0;
        cout = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sout[i] = res_q[i].s;
            cout[i] = res_q[i].c;
        end
    end

    assign out_valid = out_valid_q;

`ifdef HA_CARRY_CNT_EN
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [POP_W-1:0] pop_w;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] carry_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;

    // Count carry-generating lanes and add them, clamping at the counter maximum.
    always_comb begin
        pop_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_w = pop_w + POP_W'(carry_w[i]);
        end
        cnt_sum     = SUM_W'(carry_cnt_q) + SUM_W'(pop_w);
        carry_cnt_d = carry_cnt_q;
        if (in_valid) begin
            if (cnt_sum > SUM_W'(CNT_MAX)) begin
                carry_cnt_d = CNT_MAX;
            end else begin
                carry_cnt_d = cnt_sum[CNT_W-1:0];
            end
        end
    end

    // Carry-event counter register, cleared by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt_q <= '0;
        end else begin
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;
`endif

endmodule : half_adder_s

// File: tb/tb_half_adder_s.sv
// Self-checking bench for half_adder_s: a 1-lane and a 4-lane instance share
// clock, reset and in_valid; a lane-wise arithmetic model predicts outputs.
module tb_half_adder_s;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic       sout1, cout1, ov1;
    logic [3:0] sout4, cout4;
    logic       ov4;
`ifdef HA_CARRY_CNT_EN
    logic [15:0] cnt1;
    logic [3:0]  cnt4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m1_s, m1_c, m_v;
    logic [3:0] m4_s, m4_c;
    int         m_cnt1, m_cnt4;

    half_adder_s #(
        .WIDTH (1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .sout      (sout1),
        .cout      (cout1),
        .out_valid (ov1)
`ifdef HA_CARRY_CNT_EN
        ,
        .carry_cnt (cnt1)
`endif
    );

    half_adder_s #(
        .WIDTH (4)
`ifdef HA_CARRY_CNT_EN
        ,
        .CNT_W (4)
`endif
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a4),
        .b         (b4),
        .sout      (sout4),
        .cout      (cout4),
        .out_valid (ov4)
`ifdef HA_CARRY_CNT_EN
        ,
        .carry_cnt (cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, " sout1"}, 32'(sout1), 32'(m1_s));
        check({where, " cout1"}, 32'(cout1), 32'(m1_c));
        check({where, " valid1"}, 32'(ov1), 32'(m_v));
        check({where, " sout4"}, 32'(sout4), 32'(m4_s));
        check({where, " cout4"}, 32'(cout4), 32'(m4_c));
        check({where, " valid4"}, 32'(ov4), 32'(m_v));
`ifdef HA_CARRY_CNT_EN
        check({where, " cnt1"}, 32'(cnt1), 32'(m_cnt1));
        check({where, " cnt4"}, 32'(cnt4), 32'(m_cnt4));
`endif
    endtask

    task automatic model_reset();
        m1_s = 1'b0; m1_c = 1'b0; m_v = 1'b0;
        m4_s = '0;   m4_c = '0;
        m_cnt1 = 0;  m_cnt4 = 0;
    endtask

    // Called at a negedge: drive inputs, predict, clock once, check #1 after the edge.
    task automatic apply(input logic v, input logic ia1, input logic ib1,
                         input logic [3:0] ia4, input logic [3:0] ib4, input string tag);
        int t;
        int carries;
        in_valid = v; a1 = ia1; b1 = ib1; a4 = ia4; b4 = ib4;
        if (v) begin
            t = int'(ia1) + int'(ib1);
            m1_s = 1'(t % 2);
            m1_c = 1'(t / 2);
            m_cnt1 = (m_cnt1 + t / 2 > 65535) ? 65535 : m_cnt1 + t / 2;
            carries = 0;
            for (int i = 0; i < 4; i++) begin
                t = int'(ia4[i]) + int'(ib4[i]);
                m4_s[i] = 1'(t % 2);
                m4_c[i] = 1'(t / 2);
                carries += t / 2;
            end
            m_cnt4 = (m_cnt4 + carries > 15) ? 15 : m_cnt4 + carries;
        end
        m_v = v;
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    // Called at a negedge: assert rst between edges, check immediate clear, release.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
`ifdef HA_CARRY_CNT_EN
        int sat_tab[5] = '{4, 8, 12, 15, 15};
`endif
        rst = 1'b1;
        in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
        model_reset();

        // Reset held across edges
        repeat (2) @(negedge clk);
        check_outputs("reset_hold");
        rst = 1'b0;
        @(negedge clk);

        // Truth-table sweep on consecutive valid cycles
        apply(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, "sweep00");
        check("sweep00 pair", 32'({sout1, cout1}), 32'(2'b00));
        apply(1'b1, 1'b0, 1'b1, 4'h5, 4'hA, "sweep01");
        check("sweep01 pair", 32'({sout1, cout1}), 32'(2'b10));
        apply(1'b1, 1'b1, 1'b0, 4'hC, 4'h3, "sweep10");
        check("sweep10 pair", 32'({sout1, cout1}), 32'(2'b10));
        apply(1'b1, 1'b1, 1'b1, 4'hF, 4'h9, "sweep11");
        check("sweep11 pair", 32'({sout1, cout1}), 32'(2'b01));

        // 4-lane directed pattern
        apply(1'b1, 1'b0, 1'b1, 4'b1011, 4'b0110, "lanes4");
        check("lanes4 sout", 32'(sout4), 32'(4'b1101));
        check("lanes4 cout", 32'(cout4), 32'(4'b0010));

        // Capture 1+1 then hold for 3 invalid cycles with toggling inputs
        apply(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, "hold_cap");
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, k[0], ~k[0], 4'(k * 5), 4'(~k), "hold");
            check("hold sout1", 32'(sout1), 32'(1'b0));
            check("hold cout1", 32'(cout1), 32'(1'b1));
            check("hold valid", 32'(ov1), 32'(1'b0));
        end

        // Reset in the middle of a valid stream, then first valid after release
        apply(1'b1, 1'b1, 1'b1, 4'h7, 4'h6, "stream0");
        apply(1'b1, 1'b1, 1'b0, 4'hB, 4'hE, "stream1");
        pulse_reset("midreset");
        apply(1'b1, 1'b1, 1'b1, 4'hD, 4'h5, "post_reset");
        check("post_reset cout1", 32'(cout1), 32'(1'b1));
        check("post_reset valid", 32'(ov4), 32'(1'b1));

`ifdef HA_CARRY_CNT_EN
        // Counter saturation on 4 lanes, 4-bit counter
        pulse_reset("cnt_reset");
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, "sat");
            check("sat cnt4", 32'(cnt4), 32'(sat_tab[k]));
        end
        pulse_reset("cnt_clear");
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            apply(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_half_adder_s
